// File: rtl/npc_pkg.sv
// Shared types and constants for the naive riscv32-EM core front end.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // All-zero word decodes as an illegal instruction.
  localparam logic [31:0] INST_ILLEGAL     = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding word fetch at a time, hands the
// fetched instruction and its PC to decode, and stops for good on halt.
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] ILLEGAL  = INST_ILLEGAL
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        halted,
  output logic [31:0] retire_cnt
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        err_q, err_d;
  logic [31:0] retire_q, retire_d;

  // Next-state for the fetch FSM, the PC and the decode holding register.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    retire_d  = retire_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d    = imem_rsp_err ? ILLEGAL : imem_rsp_data;
          inst_pc_d = pc_q;
          err_d     = imem_rsp_err;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (inst_ready) begin
          retire_d = retire_q + 32'd1;
          if (halt) begin
            state_d = HALT;
          end else begin
            pc_d = next_pc;
            if (next_pc[1:0] != 2'b00) begin
              // Misaligned target: no bus access, present an illegal fault instruction instead.
              inst_d    = ILLEGAL;
              inst_pc_d = next_pc;
              err_d     = 1'b1;
            end else begin
              state_d = REQ;
            end
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= ILLEGAL;
      inst_pc_q <= RESET_PC;
      err_q     <= 1'b0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      retire_q  <= retire_d;
    end
  end

  // Handshake outputs decode straight from the state register.
  always_comb begin
    imem_req_valid = (state_q == REQ);
    imem_req_addr  = pc_q;
    imem_rsp_ready = (state_q == WAIT);
    inst_valid     = (state_q == VALID);
    halted         = (state_q == HALT);
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    fetch_err      = err_q;
    retire_cnt     = retire_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: the bench plays both instruction memory and the
// committing core, and predicts every presented instruction from the address alone.
module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, next_pc, retire_cnt;
  logic        fetch_err, halt, halted;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .next_pc        (next_pc),
    .halt           (halt),
    .halted         (halted),
    .retire_cnt     (retire_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents as a pure function of address; one address range faults.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit mem_err(input logic [31:0] a);
    logic [4:0] idx;
    idx = a[6:2];
    return (idx == 5'h1B) && (a != RPC);
  endfunction

  // ---------------- memory model ----------------
  bit          hold_ready = 1'b1;
  bit          fast_mem   = 1'b1;
  bit          stale_on   = 1'b0;
  int          delay_force = -1;
  bit          pending = 1'b0;
  int          delay;
  logic [31:0] paddr;
  bit          req_fire_q = 1'b0, rsp_fire_q = 1'b0, stall_q = 1'b0;
  logic [31:0] fire_addr, stall_addr;
  int unsigned req_count = 0;
  logic [31:0] last_req_addr = '0;

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (rsp_fire_q) begin
          if (!pending) begin
            n_fail++;
            $display("FAIL rsp_unrequested: got accepted expected ignored");
          end
          pending = 1'b0;
        end
        if (req_fire_q) begin
          pending       = 1'b1;
          paddr         = fire_addr;
          req_count++;
          last_req_addr = fire_addr;
          delay = (delay_force >= 0) ? delay_force : (fast_mem ? 0 : int'($urandom_range(0, 3)));
        end
      end
      imem_req_ready = hold_ready ? 1'b0 : (fast_mem ? 1'b1 : ($urandom_range(0, 2) != 0));
      if (pending && delay == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        imem_rsp_err   = mem_err(paddr);
      end else begin
        if (pending) delay--;
        if (stale_on || (!fast_mem && !pending && $urandom_range(0, 5) == 0)) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEAD_BEEF;
          imem_rsp_err   = 1'($urandom_range(0, 1));
        end else begin
          imem_rsp_valid = 1'b0;
        end
      end
      #1;
      if (stall_q && !rst) begin
        chk("req_valid_held", 32'(imem_req_valid), 32'd1);
        chk("req_addr_held", imem_req_addr, stall_addr);
      end
      req_fire_q = imem_req_valid && imem_req_ready && !rst;
      fire_addr  = imem_req_addr;
      rsp_fire_q = imem_rsp_valid && imem_rsp_ready && !rst;
      stall_q    = imem_req_valid && !imem_req_ready && !rst;
      stall_addr = imem_req_addr;
    end
  end

  // ---------------- core side ----------------
  int unsigned model_retired = 0;

  task automatic wait_inst(output bit ok);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (inst_valid === 1'b1) return;
      @(negedge clk);
    end
    ok = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL inst_valid_timeout: got 0 expected 1 within 100 cycles");
  endtask

  task automatic commit(input logic [31:0] np, input logic h);
    inst_ready = 1'b1;
    next_pc    = np;
    halt       = h;
    @(negedge clk);
    inst_ready = 1'b0;
    halt       = 1'b0;
    model_retired++;
  endtask

  // Expected presentation for a given target PC.
  task automatic expect_inst(input logic [31:0] pc);
    logic [1:0] lo;
    bit         e;
    lo = pc[1:0];
    e  = (lo != 2'b00) || mem_err(pc);
    chk("inst", inst, e ? 32'h0 : mem_word(pc));
    chk("inst_pc", inst_pc, pc);
    chk("fetch_err", 32'(fetch_err), 32'(e));
  endtask

  typedef struct {
    logic [31:0] next_pc;
    logic [31:0] exp_inst;
    logic        exp_err;
    int unsigned exp_reqs;
  } vec_t;

  vec_t        vecs[7];
  bit          ok;
  int unsigned rc0;
  logic [31:0] np, held;

  initial begin
    vecs[0] = '{32'h8000_0010, mem_word(32'h8000_0010), 1'b0, 1};
    vecs[1] = '{32'h8000_006C, 32'h0000_0000,           1'b1, 1};
    vecs[2] = '{32'h8000_0002, 32'h0000_0000,           1'b1, 0};
    vecs[3] = '{32'h8000_0003, 32'h0000_0000,           1'b1, 0};
    vecs[4] = '{32'h8000_0104, mem_word(32'h8000_0104), 1'b0, 1};
    vecs[5] = '{32'h8000_0101, 32'h0000_0000,           1'b1, 0};
    vecs[6] = '{32'h8000_0008, mem_word(32'h8000_0008), 1'b0, 1};

    rst = 1'b1; inst_ready = 1'b0; next_pc = '0; halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, RPC);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);

    // Release with memory stalling the request for five cycles.
    rst = 1'b0;
    #1 chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 3 && imem_req_valid !== 1'b1; i++) @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RPC);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_req_addr, RPC);
      @(negedge clk);
    end
    chk("stall_no_handshake", req_count, 32'd0);
    hold_ready = 1'b0;
    wait_inst(ok);
    chk("one_handshake", req_count, 32'd1);
    expect_inst(RPC);

    // Directed table of commits.
    foreach (vecs[i]) begin
      rc0 = req_count;
      commit(vecs[i].next_pc, 1'b0);
      chk("tbl_retire", retire_cnt, model_retired);
      wait_inst(ok);
      chk("tbl_inst", inst, vecs[i].exp_inst);
      chk("tbl_inst_pc", inst_pc, vecs[i].next_pc);
      chk("tbl_fetch_err", 32'(fetch_err), 32'(vecs[i].exp_err));
      chk("tbl_req_count", req_count - rc0, vecs[i].exp_reqs);
      if (vecs[i].exp_reqs != 0) chk("tbl_req_addr", last_req_addr, vecs[i].next_pc);
    end

    // Randomised traffic with a stalling memory and spurious responses.
    fast_mem = 1'b0;
    for (int n = 0; n < 120; n++) begin
      held = inst;
      for (int w = $urandom_range(0, 2); w > 0; w--) begin
        @(negedge clk);
        chk("hold_inst_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", inst, held);
      end
      np = RPC | ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 7) == 0) np = np | 32'($urandom_range(1, 3));
      rc0 = req_count;
      commit(np, 1'b0);
      wait_inst(ok);
      expect_inst(np);
      chk("rnd_retire", retire_cnt, model_retired);
      chk("rnd_req_count", req_count - rc0, (np[1:0] == 2'b00) ? 32'd1 : 32'd0);
      if (np[1:0] == 2'b00) chk("rnd_req_addr", last_req_addr, np);
    end

    // Halt together with a misaligned target: halt wins, nothing fetched afterwards.
    rc0 = req_count;
    commit(32'h8000_0003, 1'b1);
    chk("halt_retire", retire_cnt, model_retired);
    for (int i = 0; i < 20; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      next_pc    = $urandom;
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
      chk("halt_inst_valid", 32'(inst_valid), 32'd0);
    end
    inst_ready = 1'b0;
    chk("halt_no_req", req_count - rc0, 32'd0);
    chk("halt_retire_frozen", retire_cnt, model_retired);

    // Reset in WAIT, then a stale response while idle/requesting.
    fast_mem = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    delay_force = 6;
    rc0 = req_count;
    for (int i = 0; i < 20 && req_count == rc0; i++) @(negedge clk);
    chk("wait_req_issued", req_count - rc0, 32'd1);
    chk("wait_rsp_ready", 32'(imem_rsp_ready), 32'd1);
    rst = 1'b1; stale_on = 1'b1; hold_ready = 1'b1; delay_force = -1;
    model_retired = 0;
    @(negedge clk);
    #1 chk("rst2_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    chk("rst2_retire", retire_cnt, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("stale_rsp_ready", 32'(imem_rsp_ready), 32'd0);
      chk("stale_inst_valid", 32'(inst_valid), 32'd0);
    end
    chk("fresh_req_addr", imem_req_addr, RPC);
    stale_on = 1'b0; hold_ready = 1'b0;
    wait_inst(ok);
    expect_inst(RPC);
    chk("fresh_retire", retire_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
